// File: rtl/input_pingpong_buffer_pkg.sv
// Shared types and defaults for the ping-pong input activation buffer.
// Reused by the layer controller for bank state decoding.
package input_pingpong_buffer_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  localparam int DEF_D_WIDTH = 16;
  localparam int DEF_A_WIDTH = 4;

endpackage

// File: rtl/input_pingpong_buffer_bank_ram.sv
// Simple dual-port bank RAM: sync write, registered sync read.
// Only the read register is reset; array contents survive reset.
module buffer_bank_ram
  import input_pingpong_buffer_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/input_pingpong_buffer.sv
// Ping-pong input activation buffer: loader fills one bank while
// the neuron array reads the other; ownership moves via fill/release.
module input_pingpong_buffer
  import input_pingpong_buffer_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int A_WIDTH = DEF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [D_WIDTH-1:0] w_data,
  input  logic               w_last,
  output logic               r_bank_ready,
  output logic [A_WIDTH:0]   r_len,
  input  logic               r_en,
  input  logic [A_WIDTH-1:0] r_addr,
  output logic [D_WIDTH-1:0] r_data,
  output logic               r_valid,
  input  logic               r_done
);

  bank_state_e        state_q [2];
  logic [A_WIDTH:0]   len_q   [2];
  logic [D_WIDTH-1:0] q       [2];
  logic               wbank_q;
  logic               rbank_q;
  logic               rsel_q;
  logic [A_WIDTH-1:0] waddr_q;

  logic wr_acc;
  logic wr_close;
  logic rd_acc;
  logic rel;

  assign w_ready      = (state_q[wbank_q] == BANK_EMPTY);
  assign r_bank_ready = (state_q[rbank_q] == BANK_FULL);
  assign r_len        = r_bank_ready ? len_q[rbank_q] : '0;

  assign wr_acc   = w_valid && w_ready;
  assign wr_close = wr_acc && (w_last || (waddr_q == '1));
  assign rd_acc   = r_en && r_bank_ready;
  assign rel      = r_done && r_bank_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);
    buffer_bank_ram #(
      .D_WIDTH(D_WIDTH),
      .A_WIDTH(A_WIDTH)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_acc && (wbank_q == SEL)),
      .waddr(waddr_q),
      .wdata(w_data),
      .re   (rd_acc && (rbank_q == SEL)),
      .raddr(r_addr),
      .rdata(q[b])
    );
  end

  // Idle RAM outputs hold, so the mux select alone keeps r_data stable.
  assign r_data = q[rsel_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BANK_EMPTY;
        len_q[b]   <= '0;
      end
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      rsel_q  <= 1'b0;
      waddr_q <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_acc;
      if (rd_acc) rsel_q <= rbank_q;
      if (wr_acc) begin
        waddr_q <= waddr_q + A_WIDTH'(1);
      end
      if (wr_close) begin
        state_q[wbank_q] <= BANK_FULL;
        len_q[wbank_q]   <= {1'b0, waddr_q} + (A_WIDTH+1)'(1);
        waddr_q          <= '0;
        wbank_q          <= ~wbank_q;
      end
      // Close and release never target the same bank.
      if (rel) begin
        state_q[rbank_q] <= BANK_EMPTY;
        rbank_q          <= ~rbank_q;
      end
    end
  end

endmodule

// File: tb/tb_input_pingpong_buffer.sv
// Self-checking bench: FIFO-of-vectors model plus literal pins.
module tb_input_pingpong_buffer;

  logic        clk;
  logic        rst;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        w_last;
  logic        r_bank_ready;
  logic [4:0]  r_len;
  logic        r_en;
  logic [3:0]  r_addr;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_done;

  input_pingpong_buffer #(
    .D_WIDTH(16),
    .A_WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .w_last      (w_last),
    .r_bank_ready(r_bank_ready),
    .r_len       (r_len),
    .r_en        (r_en),
    .r_addr      (r_addr),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .r_done      (r_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: queue of completed vectors (index 0 is the reader's),
  // plus the vector currently being loaded.
  logic [15:0] fdat [2][16];
  int          flen [2];
  int          cnt;
  logic [15:0] part [16];
  int          plen;
  logic [15:0] exp_rdata;
  bit          exp_rvalid;

  always @(posedge clk) begin
    bit w_rdy, r_rdy;
    if (rst) begin
      cnt = 0;
      plen = 0;
      exp_rdata = '0;
      exp_rvalid = 1'b0;
    end else begin
      w_rdy = (cnt < 2);
      r_rdy = (cnt > 0);
      if (r_en && r_rdy) begin
        exp_rdata = fdat[0][r_addr];
        exp_rvalid = 1'b1;
      end else begin
        exp_rvalid = 1'b0;
      end
      if (r_done && r_rdy) begin
        for (int i = 0; i < 16; i++) fdat[0][i] = fdat[1][i];
        flen[0] = flen[1];
        cnt--;
      end
      if (w_valid && w_rdy) begin
        part[plen] = w_data;
        plen++;
        if (w_last || plen == 16) begin
          for (int i = 0; i < 16; i++) fdat[cnt][i] = part[i];
          flen[cnt] = plen;
          cnt++;
          plen = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_w_ready", 32'(w_ready), 32'(cnt < 2));
      chk("m_r_bank_ready", 32'(r_bank_ready), 32'(cnt > 0));
      chk("m_r_len", 32'(r_len), (cnt > 0) ? 32'(flen[0]) : 32'd0);
      chk("m_r_valid", 32'(r_valid), 32'(exp_rvalid));
      chk("m_r_data", 32'(r_data), 32'(exp_rdata));
    end
  end

  task automatic cyc(input logic wv, input logic [15:0] wd,
                     input logic wl, input logic re,
                     input logic [3:0] ra, input logic rd);
    w_valid = wv;
    w_data  = wd;
    w_last  = wl;
    r_en    = re;
    r_addr  = ra;
    r_done  = rd;
    @(negedge clk);
  endtask

  task automatic rd_at(input logic [3:0] a);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, a, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_w_ready"}, 32'(w_ready), 32'd1);
    chk({tag, "_r_bank_ready"}, 32'(r_bank_ready), 32'd0);
    chk({tag, "_r_len"}, 32'(r_len), 32'd0);
    chk({tag, "_r_valid"}, 32'(r_valid), 32'd0);
    chk({tag, "_r_data"}, 32'(r_data), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk_reset_state("rst0");

    for (int i = 0; i < 16; i++)
      cyc(1'b1, 16'(i + 1), 1'b0, 1'b0, 4'h0, 1'b0);
    chk("full16_ready", 32'(r_bank_ready), 32'd1);
    chk("full16_len", 32'(r_len), 32'd16);
    chk("full16_w_ready", 32'(w_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      rd_at(4'(i));
      chk("rd16_data", 32'(r_data), 32'(i + 1));
      chk("rd16_valid", 32'(r_valid), 32'd1);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("idle_valid", 32'(r_valid), 32'd0);
    chk("idle_hold", 32'(r_data), 32'h0010);

    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'h3, 1'b1);
    chk("rdrel_valid", 32'(r_valid), 32'd1);
    chk("rdrel_data", 32'(r_data), 32'h0004);
    chk("rdrel_ready", 32'(r_bank_ready), 32'd0);

    for (int i = 0; i < 5; i++)
      cyc(1'b1, 16'h0101 + 16'(i), (i == 4), 1'b0, 4'h0, 1'b0);
    chk("short_ready", 32'(r_bank_ready), 32'd1);
    chk("short_len", 32'(r_len), 32'd5);
    rd_at(4'h4);
    chk("short_rd4", 32'(r_data), 32'h0105);

    for (int i = 0; i < 16; i++)
      cyc(1'b1, 16'h0201 + 16'(i), 1'b0, 1'b0, 4'h0, 1'b0);
    chk("both_full_w_ready", 32'(w_ready), 32'd0);
    repeat (4) cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("stall_w_ready", 32'(w_ready), 32'd0);
    chk("stall_len", 32'(r_len), 32'd5);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("unstall_w_ready", 32'(w_ready), 32'd1);
    chk("unstall_len", 32'(r_len), 32'd16);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("held_closed", 32'(w_ready), 32'd0);

    rd_at(4'h0);
    chk("b0_rd0", 32'(r_data), 32'h0201);
    rd_at(4'hF);
    chk("b0_rd15", 32'(r_data), 32'h0210);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'h7, 1'b1);
    chk("b0_rd7_rel", 32'(r_data), 32'h0208);
    chk("held_len", 32'(r_len), 32'd1);
    rd_at(4'h0);
    chk("held_data", 32'(r_data), 32'hBEEF);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("drained_ready", 32'(r_bank_ready), 32'd0);

    cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'h2, 1'b1);
    chk("empty_valid", 32'(r_valid), 32'd0);
    chk("empty_ready", 32'(r_bank_ready), 32'd0);
    chk("empty_hold", 32'(r_data), 32'hBEEF);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'h0401 + 16'(i), (i == 2), 1'b0, 4'h0, 1'b0);
    chk("post_empty_len", 32'(r_len), 32'd3);
    rd_at(4'h1);
    chk("post_empty_rd1", 32'(r_data), 32'h0402);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b1);

    for (int i = 0; i < 7; i++)
      cyc(1'b1, 16'h0501 + 16'(i), 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    chk_reset_state("rst1");
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 16'h0601 + 16'(i), 1'b0, 1'b0, 4'h0, 1'b0);
    chk("rfill_len", 32'(r_len), 32'd16);
    rd_at(4'h0);
    chk("rfill_rd0", 32'(r_data), 32'h0601);
    rd_at(4'h6);
    chk("rfill_rd6", 32'(r_data), 32'h0607);
    rd_at(4'hF);
    chk("rfill_rd15", 32'(r_data), 32'h0610);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
